seg_scan_ctrl: RTL

Time-multiplexing scan controller for the four-digit seven-segment display on the Basys board. It holds a 4-digit BCD value plus per-digit decimal points and drives one shared single-digit decoder. Each scan slot drives one nibble/DP pair into the decoder and asserts the matching active-low anode. New values are staged by a load strobe and committed only at a frame boundary, so a digit set is never displayed half-old/half-new.

---
 rtl/seg_scan_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-aligned commit of staged values.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always lit).
module seg_scan_ctrl #(
  parameter int unsigned DIV = 50000,
  parameter int unsigned CW  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [3:0]  n,
  output logic        dp_n,
  output logic        pending,
  output logic        frame
);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  // {dp[3:0], digits[15:0]}, all decimal points off
  localparam logic [19:0] VAL_RST = {4'b1111, 16'h0000};

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [19:0]   stg_q, stg_d;
  logic [19:0]   shd_q, shd_d;
  logic          pend_q, pend_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    n_q, n_d;
  logic          dp_n_q, dp_n_d;
  logic          tick_s, wrap_s, blank_s, dp_s;
  logic [3:0]    nib_s;

  assign tick_s = en && (cnt_q == CNT_MAX);
  assign wrap_s = tick_s && (idx_q == 2'd3);

  // Select the nibble, DP and blanking decision for the digit in the current slot
  always_comb begin
    nib_s   = shd_q[3:0];
    dp_s    = shd_q[16];
    blank_s = 1'b0;
    case (idx_q)
      2'd0:    begin nib_s = shd_q[3:0];   dp_s = shd_q[16]; end
      2'd1:    begin nib_s = shd_q[7:4];   dp_s = shd_q[17]; end
      2'd2:    begin nib_s = shd_q[11:8];  dp_s = shd_q[18]; end
      2'd3:    begin nib_s = shd_q[15:12]; dp_s = shd_q[19]; end
      default: begin nib_s = shd_q[3:0];   dp_s = shd_q[16]; end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd3:    blank_s = (shd_q[15:12] == 4'h0);
      2'd2:    blank_s = (shd_q[15:8] == 8'h00);
      2'd1:    blank_s = (shd_q[15:4] == 12'h000);
      default: blank_s = 1'b0;
    endcase
`else
    blank_s = 1'b0;
`endif
  end

  // Next-state: prescaler/index, staging and commit, registered display outputs
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    stg_d  = stg_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    an_d   = an_q;
    n_d    = n_q;
    dp_n_d = dp_n_q;

    if (!en) begin
      cnt_d = {CW{1'b0}};
      idx_d = 2'd0;
    end else if (tick_s) begin
      cnt_d = {CW{1'b0}};
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end

    // A load landing on the wrap bypasses staging so it is never held a whole frame
    if (load && wrap_s) begin
      shd_d  = {dp_in, digits_in};
      pend_d = 1'b0;
    end else if (load) begin
      stg_d  = {dp_in, digits_in};
      pend_d = 1'b1;
    end else if (wrap_s && pend_q) begin
      shd_d  = stg_q;
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    if (!en) begin
      an_d   = 4'b1111;
      dp_n_d = 1'b1;
    end else if (blank_s) begin
      an_d   = 4'b1111;
      n_d    = nib_s;
      dp_n_d = 1'b1;
    end else begin
      an_d   = ~(4'b0001 << idx_q);
      n_d    = nib_s;
      dp_n_d = dp_s;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= {CW{1'b0}};
      idx_q  <= 2'd0;
      stg_q  <= VAL_RST;
      shd_q  <= VAL_RST;
      pend_q <= 1'b0;
      an_q   <= 4'b1111;
      n_q    <= 4'h0;
      dp_n_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      stg_q  <= stg_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      an_q   <= an_d;
      n_q    <= n_d;
      dp_n_q <= dp_n_d;
    end
  end

  assign an      = an_q;
  assign n       = n_q;
  assign dp_n    = dp_n_q;
  assign pending = pend_q;
  assign frame   = wrap_s;
endmodule
